traffic_light_ctrl: RTL
=======================

# traffic_light_ctrl

Parametrised two-road intersection controller: the next generation of the single-road green/yellow/red sequencer. It drives two mutually exclusive light sets (NS and EW) with programmable per-phase durations and all-red clearance. It also provides a maintenance flashing-yellow mode and an optional pedestrian request that shortens green and extends clearance into a walk interval. It sits at the top of the light subsystem and feeds lamp drivers directly.

## Interface
- GREEN_CYC, 16, green phase length in clk cycles (≥ MIN_GREEN_CYC)
- YELLOW_CYC, 4, yellow phase length (≥1)
- CLEAR_CYC, 2, all-red clearance length (≥1)
- MIN_GREEN_CYC, 4, minimum green before pedestrian truncation (≥1)
- WALK_CYC, 8, all-red length when a pedestrian request is being served (≥ CLEAR_CYC)
- FLASH_CYC, 3, half-period of flashing yellow (≥1)
- CNT_W, 8, phase counter width; every duration ≤ 2^CNT_W
- clk  in  1  clock; reset rstn, synchronous, active-low; clock clk
- rstn  in  1  synchronous active-low reset
- flash_en  in  1  level: 1 = maintenance flashing mode
- ped_req  in  1  pedestrian request, any pulse width (PED_REQ_EN only)
- ns_green, ns_yellow, ns_red  out  1 each  NS lamps, registered
- ew_green, ew_yellow, ew_red  out  1 each  EW lamps, registered
- ped_walk  out  1  walk signal, registered (tied 0 without PED_REQ_EN)
- ped_pend  out  1  request latched, not yet served (tied 0 without PED_REQ_EN)

## Operation
- States: NS_G → NS_Y → CLR_A → EW_G → EW_Y → CLR_B → NS_G; plus FLASH.
- Up-counter cnt (CNT_W bits) clears to 0 on every state entry and increments each cycle. The state advances when cnt == DUR−1, where DUR is the current state's duration. Each state therefore lasts exactly DUR cycles.
- Lamps are decoded from the state; exactly one lamp per road is on outside FLASH:
  - NS_G: ns_green=1, ew_red=1.
  - NS_Y: ns_yellow=1, ew_red=1.
  - CLR_A/CLR_B: both red.
  - EW_G and EW_Y mirror NS_G and NS_Y.
- FLASH: all greens and reds 0. ns_yellow = ew_yellow = flash bit, which starts at 1 on entry and toggles each time cnt reaches FLASH_CYC−1 (cnt then clears).
- flash_en=1 has priority over every other transition: from any state, FLASH is entered at the next edge. Leaving FLASH (flash_en=0) goes to CLR_B, so NS_G follows after the clearance.
- Pedestrian handling (PED_REQ_EN):
  - ped_pend is set on ped_req=1 in any state.
  - In NS_G/EW_G with ped_pend=1, the state advances to yellow when cnt ≥ MIN_GREEN_CYC−1, or at normal green end, whichever comes first.
  - On entry to CLR_A/CLR_B with ped_pend=1: ped_walk is set, ped_pend clears, and that clearance lasts WALK_CYC instead of CLEAR_CYC. ped_walk clears on exit.
  - A ped_req arriving during a walk interval re-pends and is served at the next clearance.
  - Entering FLASH clears ped_walk but keeps ped_pend.

## Timing
- Reset (rstn=0 at an edge): state NS_G, cnt=0, flash bit 0. Outputs ns_green=1, ew_red=1, all other lamps 0, ped_walk=0, ped_pend=0. Reset mid-phase aborts immediately and the full sequence restarts.
- Outputs are registered and change on the same edge as the state register, with zero extra latency.
- ped_req sampled at edge k → ped_pend=1 after edge k. Truncation takes effect at the first edge where the truncation condition above holds.
- Nominal full cycle: 2·(GREEN_CYC+YELLOW_CYC+CLEAR_CYC) = 44 cycles at defaults.

## Configuration
- PED_REQ_EN defined: ped_req latching, green truncation, WALK_CYC clearance, ped_walk/ped_pend outputs active.
- Not defined: ped_req ignored, ped_walk and ped_pend constant 0, pedestrian logic removed. Sequence and FLASH behaviour are otherwise identical.

## Test plan
- Reset, then free-run with defaults → NS_G 16, NS_Y 4, CLR_A 2, EW_G 16, EW_Y 4, CLR_B 2 cycles; repeats every 44 cycles; never both roads non-red.
- ped_req pulse 1 cycle at NS_G cnt=1 (PED_REQ_EN) → NS_G ends after 4 cycles total; CLR_A lasts 8 cycles with ped_walk=1; ped_pend 0 afterwards.
- ped_req at NS_G cnt=10 → immediate advance to NS_Y at the next edge; a second ped_req during the walk interval → served in CLR_B.
- flash_en=1 during EW_G → FLASH at the next edge, yellows toggling 3 on/3 off. flash_en=0 → CLR_B for 2 cycles, then NS_G.
- rstn=0 for 1 cycle during NS_Y with ped_pend=1 → outputs return to reset values; ped_pend=0; NS_G lasts a full 16 cycles.
- PED_REQ_EN undefined, ped_req held 1 → timing identical to the free-run case; ped_walk=0 throughout.

Source files
------------

// File: rtl/traffic_light_ctrl_if.sv
// Signal bundle between the two-road traffic light controller and its
// environment: mode/request inputs toward the controller, lamp and
// pedestrian status outputs from it.
interface traffic_light_ctrl_if;
    logic flash_en;
    logic ped_req;
    logic ns_green;
    logic ns_yellow;
    logic ns_red;
    logic ew_green;
    logic ew_yellow;
    logic ew_red;
    logic ped_walk;
    logic ped_pend;

    // Environment side: drives the mode/request levels, observes the lamps.
    modport master (
        output flash_en, ped_req,
        input  ns_green, ns_yellow, ns_red,
        input  ew_green, ew_yellow, ew_red,
        input  ped_walk, ped_pend
    );

    // Controller side.
    modport slave (
        input  flash_en, ped_req,
        output ns_green, ns_yellow, ns_red,
        output ew_green, ew_yellow, ew_red,
        output ped_walk, ped_pend
    );
endinterface

// File: rtl/traffic_light_ctrl.sv
// Two-road (NS/EW) intersection controller with programmable phase lengths,
// all-red clearance and a maintenance flashing-yellow mode.
// Optional feature macro: PED_REQ_EN -- pedestrian request latching, green
// truncation after MIN_GREEN_CYC and a WALK_CYC walk interval in clearance.
// Without it ped_req is ignored and ped_walk/ped_pend are constant 0.
module traffic_light_ctrl #(
    parameter int GREEN_CYC     = 16,
    parameter int YELLOW_CYC    = 4,
    parameter int CLEAR_CYC     = 2,
    parameter int MIN_GREEN_CYC = 4,
    parameter int WALK_CYC      = 8,
    parameter int FLASH_CYC     = 3,
    parameter int CNT_W         = 8
) (
    input logic                 clk,
    input logic                 rstn,
    traffic_light_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        NS_G  = 3'd0,
        NS_Y  = 3'd1,
        CLR_A = 3'd2,
        EW_G  = 3'd3,
        EW_Y  = 3'd4,
        CLR_B = 3'd5,
        FLASH = 3'd6
    } state_t;

    // Last counter value of each phase: a phase of DUR cycles ends at DUR-1.
    localparam logic [CNT_W-1:0] G_LAST = CNT_W'(GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(CLEAR_CYC - 1);
    localparam logic [CNT_W-1:0] F_LAST = CNT_W'(FLASH_CYC - 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               flash_q;
    logic               ns_green_q, ns_yellow_q, ns_red_q;
    logic               ew_green_q, ew_yellow_q, ew_red_q;

    state_t             nxt_state;
    logic [CNT_W-1:0]   nxt_cnt;
    logic               nxt_flash;
    logic               entering;
    logic               ph_done;
    logic               nxt_is_clr;
    logic               nxt_ns_g, nxt_ns_y, nxt_ns_r;
    logic               nxt_ew_g, nxt_ew_y, nxt_ew_r;

    logic               pend_q;
    logic               walk_q;

`ifdef PED_REQ_EN
    localparam logic [CNT_W-1:0] M_LAST = CNT_W'(MIN_GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] W_LAST = CNT_W'(WALK_CYC - 1);

    logic               serve;
    logic               nxt_pend;
    logic               nxt_walk;
`else
    localparam int unused_ped_params = MIN_GREEN_CYC + WALK_CYC;
    logic unused_ped_req;
    assign unused_ped_req = bus.ped_req;
    assign pend_q = 1'b0;
    assign walk_q = 1'b0;
`endif

    function automatic state_t succ(input state_t s);
        case (s)
            NS_G:    succ = NS_Y;
            NS_Y:    succ = CLR_A;
            CLR_A:   succ = EW_G;
            EW_G:    succ = EW_Y;
            EW_Y:    succ = CLR_B;
            default: succ = NS_G;
        endcase
    endfunction

    // Decide whether the current phase ends on this edge.
    always_comb begin
        ph_done = 1'b0;
        case (state)
            NS_G, EW_G: begin
                ph_done = (cnt == G_LAST);
`ifdef PED_REQ_EN
                if (pend_q && (cnt >= M_LAST)) ph_done = 1'b1;
`endif
            end
            NS_Y, EW_Y: ph_done = (cnt == Y_LAST);
            CLR_A, CLR_B: begin
`ifdef PED_REQ_EN
                ph_done = walk_q ? (cnt == W_LAST) : (cnt == C_LAST);
`else
                ph_done = (cnt == C_LAST);
`endif
            end
            default: ph_done = 1'b0;
        endcase
    end

    // Next state, counter and flash bit; flash_en overrides everything.
    always_comb begin
        nxt_state = state;
        if (bus.flash_en)        nxt_state = FLASH;
        else if (state == FLASH) nxt_state = CLR_B;
        else if (ph_done)        nxt_state = succ(state);

        entering   = (nxt_state != state);
        nxt_is_clr = (nxt_state == CLR_A) || (nxt_state == CLR_B);

        if (entering)                            nxt_cnt = '0;
        else if (state == FLASH && cnt == F_LAST) nxt_cnt = '0;
        else                                     nxt_cnt = cnt + 1'b1;

        nxt_flash = 1'b0;
        if (nxt_state == FLASH) begin
            if (entering)           nxt_flash = 1'b1;
            else if (cnt == F_LAST) nxt_flash = ~flash_q;
            else                    nxt_flash = flash_q;
        end
    end

    // Lamp decode from the next state so lamps register with the state.
    always_comb begin
        nxt_ns_g = 1'b0;
        nxt_ns_y = 1'b0;
        nxt_ns_r = 1'b0;
        nxt_ew_g = 1'b0;
        nxt_ew_y = 1'b0;
        nxt_ew_r = 1'b0;
        case (nxt_state)
            NS_G:  begin nxt_ns_g = 1'b1; nxt_ew_r = 1'b1; end
            NS_Y:  begin nxt_ns_y = 1'b1; nxt_ew_r = 1'b1; end
            EW_G:  begin nxt_ew_g = 1'b1; nxt_ns_r = 1'b1; end
            EW_Y:  begin nxt_ew_y = 1'b1; nxt_ns_r = 1'b1; end
            FLASH: begin nxt_ns_y = nxt_flash; nxt_ew_y = nxt_flash; end
            default: begin nxt_ns_r = 1'b1; nxt_ew_r = 1'b1; end
        endcase
    end

    // Phase state machine with registered lamp outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= NS_G;
            cnt         <= '0;
            flash_q     <= 1'b0;
            ns_green_q  <= 1'b1;
            ns_yellow_q <= 1'b0;
            ns_red_q    <= 1'b0;
            ew_green_q  <= 1'b0;
            ew_yellow_q <= 1'b0;
            ew_red_q    <= 1'b1;
        end else begin
            state       <= nxt_state;
            cnt         <= nxt_cnt;
            flash_q     <= nxt_flash;
            ns_green_q  <= nxt_ns_g;
            ns_yellow_q <= nxt_ns_y;
            ns_red_q    <= nxt_ns_r;
            ew_green_q  <= nxt_ew_g;
            ew_yellow_q <= nxt_ew_y;
            ew_red_q    <= nxt_ew_r;
        end
    end

`ifdef PED_REQ_EN
    // A pending request is served on entry to a clearance; a request seen on
    // the same edge re-pends for the following clearance.
    always_comb begin
        serve    = nxt_is_clr && entering && pend_q;
        nxt_pend = (pend_q && !serve) || bus.ped_req;
        nxt_walk = nxt_is_clr && (serve || (walk_q && !entering));
    end

    // Pedestrian request and walk registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pend_q <= 1'b0;
            walk_q <= 1'b0;
        end else begin
            pend_q <= nxt_pend;
            walk_q <= nxt_walk;
        end
    end
`endif

    assign bus.ns_green  = ns_green_q;
    assign bus.ns_yellow = ns_yellow_q;
    assign bus.ns_red    = ns_red_q;
    assign bus.ew_green  = ew_green_q;
    assign bus.ew_yellow = ew_yellow_q;
    assign bus.ew_red    = ew_red_q;
    assign bus.ped_walk  = walk_q;
    assign bus.ped_pend  = pend_q;

endmodule
